// File: rtl/pipeline_stall_controller_pkg.sv
// Shared definitions for the pipeline stall controller: FSM encoding and
// default hazard/timeout parameters.
package pipeline_stall_controller_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_e;

  localparam int          DEF_TIMEOUT_CYC = 255;
  localparam logic [4:0]  DEF_ZERO_REG    = 5'd31;
  localparam int          WAIT_W          = 8;
  localparam int          STALL_W         = 16;

endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Saturating up-counter with enable and asynchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Hazard and memory-wait stall control for a 5-stage pipeline: freezes,
// flushes and redirects the pipeline registers from one combinational decision.
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter int         TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter logic [4:0] ZERO_REG    = DEF_ZERO_REG
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        IDEX_MemRead,
  input  logic [4:0]  IDEX_rd,
  input  logic [4:0]  IFID_rn,
  input  logic [4:0]  IFID_rm,
  input  logic        EXMEM_BranchTaken,
  input  logic        DMem_Req,
  input  logic        DMem_Ready,
  output logic        PC_WriteEn,
  output logic        IFID_WriteEn,
  output logic        IFID_Flush,
  output logic        IDEX_Flush,
  output logic        EXMEM_Flush,
  output logic        Pipe_Hold,
  output logic        PC_SelBranch,
  output logic        Mem_Timeout,
  output logic [15:0] Stall_Cycles,
  output logic [1:0]  dbg_state_o
);

  // Memory handshake: an access is presented with DMem_Req and completes in
  // the first cycle DMem_Ready is high; until then the whole pipe is held.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              mem_hold;
  logic              load_use;

  assign load_use = IDEX_MemRead && (IDEX_rd != ZERO_REG) &&
                    ((IDEX_rd == IFID_rn) || (IDEX_rd == IFID_rm));

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    mem_hold = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (DMem_Req && !DMem_Ready) begin
          mem_hold = 1'b1;
          state_d  = ST_MEM_WAIT;
          wait_d   = '0;
        end
      end
      ST_MEM_WAIT: begin
        if (!DMem_Ready) begin
          mem_hold = 1'b1;
          wait_d   = wait_q + 1'b1;
          if (wait_q == WAIT_LAST) begin
            state_d = ST_ERROR;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_ERROR: begin
        mem_hold = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // A branch seen while held stays latched in EX/MEM, so it is simply acted
  // on in the first unheld cycle.
  always_comb begin
    PC_WriteEn   = 1'b1;
    IFID_WriteEn = 1'b1;
    IFID_Flush   = 1'b0;
    IDEX_Flush   = 1'b0;
    EXMEM_Flush  = 1'b0;
    Pipe_Hold    = 1'b0;
    PC_SelBranch = 1'b0;
    if (Reset || mem_hold) begin
      PC_WriteEn   = 1'b0;
      IFID_WriteEn = 1'b0;
      Pipe_Hold    = 1'b1;
    end else if (EXMEM_BranchTaken) begin
      PC_SelBranch = 1'b1;
      IFID_Flush   = 1'b1;
      IDEX_Flush   = 1'b1;
      EXMEM_Flush  = 1'b1;
    end else if (load_use) begin
      PC_WriteEn   = 1'b0;
      IFID_WriteEn = 1'b0;
      IDEX_Flush   = 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  assign Mem_Timeout = (state_q == ST_ERROR);
  assign dbg_state_o = state_q;

  sat_counter #(
    .W (STALL_W)
  ) u_stall_cnt (
    .clk_i (Clk),
    .clr_i (Reset),
    .en_i  (!PC_WriteEn),
    .cnt_o (Stall_Cycles)
  );

endmodule

// File: doc/pipeline_stall_controller.md
PIPELINE_STALL_CONTROLLER -- requirements
Module: pipeline_stall_controller

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255, max MEM_WAIT cycles before error.
REQ-002 SHALL have parameter ZERO_REG, default 5'd31, register index never treated as a hazard source.
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 IDEX_MemRead  input  1  load instruction in ID/EX.
REQ-006 IDEX_rd  input  5  destination of the ID/EX instruction.
REQ-007 IFID_rn, IFID_rm  input  5 each  source registers of the IF/ID instruction.
REQ-008 EXMEM_BranchTaken  input  1  branch resolved taken in MEM stage.
REQ-009 DMem_Req  input  1  MEM stage is issuing a data-memory access.
REQ-010 DMem_Ready  input  1  data memory completes the access this cycle.
REQ-011 PC_WriteEn, IFID_WriteEn  output  1 each  PC and IF/ID update enables.
REQ-012 IFID_Flush, IDEX_Flush, EXMEM_Flush  output  1 each  bubble insertion per register.
REQ-013 Pipe_Hold  output  1  freezes ID/EX, EX/MEM, MEM/WB registers.
REQ-014 PC_SelBranch  output  1  PC loads branch target.
REQ-015 Mem_Timeout  output  1  sticky error flag.
REQ-016 Stall_Cycles  output  16  saturating count of cycles with PC_WriteEn=0.

Function
REQ-017 SHALL implement FSM states RUN, MEM_WAIT, ERROR; control outputs are combinational from state and inputs, same cycle (no added latency).
REQ-018 RUN, DMem_Req=1 and DMem_Ready=0: Pipe_Hold=1, PC_WriteEn=0, IFID_WriteEn=0, all flushes 0, PC_SelBranch=0; next state MEM_WAIT.
REQ-019 MEM_WAIT: same outputs as REQ-018 while DMem_Ready=0; on DMem_Ready=1, outputs evaluated as RUN that cycle (pipeline advances) and next state RUN.
REQ-020 Wait counter (8 bit) SHALL clear on RUN->MEM_WAIT, increment each MEM_WAIT cycle with DMem_Ready=0; reaching TIMEOUT_CYC -> ERROR.
REQ-021 ERROR: Pipe_Hold=1, PC_WriteEn=0, IFID_WriteEn=0, flushes 0, Mem_Timeout=1; exit only by Reset.
REQ-022 Not held, EXMEM_BranchTaken=1: PC_SelBranch=1, PC_WriteEn=1, IFID_WriteEn=1, IFID_Flush=IDEX_Flush=EXMEM_Flush=1.
REQ-023 Not held, no branch, load-use hit (IDEX_MemRead=1, IDEX_rd!=ZERO_REG, IDEX_rd equals IFID_rn or IFID_rm): PC_WriteEn=0, IFID_WriteEn=0, IDEX_Flush=1, other flushes 0.
REQ-024 Otherwise: PC_WriteEn=1, IFID_WriteEn=1, all flushes 0, Pipe_Hold=0, PC_SelBranch=0.
REQ-025 Priority: ERROR > memory hold > branch flush > load-use > normal.
REQ-026 Branch during memory hold SHALL be deferred (EX/MEM frozen) and applied in the cycle DMem_Ready=1.
REQ-027 Stall_Cycles SHALL increment each cycle PC_WriteEn=0 and saturate at 16'hFFFF (no wrap).

Reset
REQ-028 Reset=1 SHALL immediately force state RUN, wait counter 0, Stall_Cycles 0, Mem_Timeout 0, including mid-MEM_WAIT or ERROR.
REQ-029 During Reset, outputs SHALL be PC_WriteEn=0, IFID_WriteEn=0, Pipe_Hold=1, flushes 0, PC_SelBranch=0.

Structure
REQ-030 Shared package SHALL hold FSM state encoding, ZERO_REG and TIMEOUT_CYC defaults.
REQ-031 Stall_Cycles SHALL be a sub-module sat_counter (width parameter, enable, async clear).

Verification
REQ-032 Load-use: IDEX_MemRead=1, IDEX_rd=5, IFID_rn=5 -> one cycle PC_WriteEn=0, IDEX_Flush=1; Stall_Cycles=1.
REQ-033 XZR: IDEX_MemRead=1, IDEX_rd=31, IFID_rm=31 -> no stall, PC_WriteEn=1.
REQ-034 Memory wait: DMem_Req=1, DMem_Ready low 4 cycles then high -> Pipe_Hold=1 for 4 cycles, RUN on 5th; Stall_Cycles=4.
REQ-035 Branch during wait: EXMEM_BranchTaken=1 with DMem_Ready=0 for 2 cycles -> no flush; flushes and PC_SelBranch=1 in cycle DMem_Ready=1.
REQ-036 Timeout: DMem_Req=1, DMem_Ready=0 for 256 cycles -> Mem_Timeout=1, ERROR held; Reset pulse -> RUN, Mem_Timeout=0, Stall_Cycles=0.
REQ-037 Saturation: force 70000 stall cycles -> Stall_Cycles=16'hFFFF.
